ex_mem_pipe_stage: RTL and testbench



---
 rtl/ex_mem_pipe_stage_pkg.sv | 25 ++
 rtl/ex_mem_pipe_stage_slot.sv | 38 +++
 rtl/ex_mem_pipe_stage.sv | 145 ++++++++++++++
 tb/tb_ex_mem_pipe_stage.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pipe_stage_pkg.sv
// Shared types and default widths for the EX/MEM pipeline stage and its storage slots.
package ex_mem_pipe_stage_pkg;

  localparam int DEF_WB_W   = 2;
  localparam int DEF_M_W    = 2;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 5;

  // Field order matches the flat vector the stage stores: control bits sit at the top.
  typedef struct packed {
    logic [DEF_WB_W-1:0]   wb;
    logic [DEF_M_W-1:0]    m;
    logic [DEF_DATA_W-1:0] result;
    logic [DEF_DATA_W-1:0] write_data;
    logic [DEF_REG_W-1:0]  rd;
    logic [DEF_REG_W-1:0]  rt;
  } payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_e;

endpackage

// File: rtl/ex_mem_pipe_stage_slot.sv
// One payload-wide storage entry; the top CTRL_W bits can be cleared without touching the data bits.
module pipe_skid_slot
  import ex_mem_pipe_stage_pkg::*;
#(
  parameter int W      = $bits(payload_t),
  parameter int CTRL_W = DEF_WB_W + DEF_M_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clr_ctrl,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr_ctrl) begin
      q_d[W-1 -: CTRL_W] = '0;
    end else if (load) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// EX/MEM pipeline register with valid/ready handshake, two-entry skid storage,
// synchronous flush and a saturating stall-cycle counter.
module ex_mem_pipe_stage
  import ex_mem_pipe_stage_pkg::*;
#(
  parameter int WB_W        = DEF_WB_W,
  parameter int M_W         = DEF_M_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int REG_W       = DEF_REG_W,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WB_W-1:0]        wbIn,
  input  logic [M_W-1:0]         mIn,
  input  logic [DATA_W-1:0]      resultIn,
  input  logic [DATA_W-1:0]      writeDataIn,
  input  logic [REG_W-1:0]       registerRdIn,
  input  logic [REG_W-1:0]       registerRtIn,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WB_W-1:0]        wbOut,
  output logic [M_W-1:0]         mOut,
  output logic [DATA_W-1:0]      resultOut,
  output logic [DATA_W-1:0]      writeDataOut,
  output logic [REG_W-1:0]       registerRdOut,
  output logic [REG_W-1:0]       registerRtOut,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int CTRL_W = WB_W + M_W;
  localparam int PAY_W  = CTRL_W + 2 * DATA_W + 2 * REG_W;

  state_e state_q, state_d;
  logic   accept, consume;
  logic   main_load, main_from_skid, skid_load, main_clr;

  logic [PAY_W-1:0] in_pay, main_in_pay, main_pay, skid_pay;
  logic [WB_W-1:0]  main_wb;
  logic [M_W-1:0]   main_m;

  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Ready depends only on registered state, so MEM back-pressure never reaches EX combinationally.
  assign in_ready  = (state_q != SKID);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  assign in_pay      = {wbIn, mIn, resultIn, writeDataIn, registerRdIn, registerRtIn};
  assign main_in_pay = main_from_skid ? skid_pay : in_pay;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    main_clr       = 1'b0;
    if (flush) begin
      state_d  = EMPTY;
      main_clr = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_load = 1'b1;
            state_d   = FULL;
          end
        end
        FULL: begin
          if (accept && consume) begin
            main_load = 1'b1;
          end else if (consume) begin
            state_d = EMPTY;
          end else if (accept) begin
            skid_load = 1'b1;
            state_d   = SKID;
          end
        end
        SKID: begin
          if (consume) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            state_d        = FULL;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_skid_slot #(.W(PAY_W), .CTRL_W(CTRL_W)) u_main (
    .clk      (clk),
    .rst      (rst),
    .load     (main_load),
    .clr_ctrl (main_clr),
    .d        (main_in_pay),
    .q        (main_pay)
  );

  // Skid contents are simply abandoned on flush; its valid bit is the state encoding.
  pipe_skid_slot #(.W(PAY_W), .CTRL_W(CTRL_W)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .clr_ctrl (1'b0),
    .d        (in_pay),
    .q        (skid_pay)
  );

  assign {main_wb, main_m, resultOut, writeDataOut, registerRdOut, registerRtOut} = main_pay;

  // Bubbles carry zero control so they can never write the register file or memory.
  assign wbOut = out_valid ? main_wb : '0;
  assign mOut  = out_valid ? main_m  : '0;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Randomised scoreboard bench for ex_mem_pipe_stage: the model is a plain FIFO of at most two held entries.
module tb_ex_mem_pipe_stage;
  import ex_mem_pipe_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [1:0]  wbIn = '0, mIn = '0;
  logic [31:0] resultIn = '0, writeDataIn = '0;
  logic [4:0]  registerRdIn = '0, registerRtIn = '0;

  logic        in_ready, out_valid;
  logic [1:0]  wbOut, mOut;
  logic [31:0] resultOut, writeDataOut;
  logic [4:0]  registerRdOut, registerRtOut;
  logic [15:0] stall_cnt;

  logic        in_ready_s, out_valid_s;
  logic [1:0]  wbOut_s, mOut_s;
  logic [31:0] resultOut_s, writeDataOut_s;
  logic [4:0]  registerRdOut_s, registerRtOut_s;
  logic [3:0]  stall_cnt_s;

  payload_t exp_q[$];
  int       n_checks = 0;
  int       n_fail = 0;
  bit       mon_en = 1'b0;
  int       stall_exp = 0;
  int       stall_exp4 = 0;

  always #5 clk = ~clk;

  ex_mem_pipe_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .wbIn(wbIn), .mIn(mIn), .resultIn(resultIn), .writeDataIn(writeDataIn),
    .registerRdIn(registerRdIn), .registerRtIn(registerRtIn),
    .out_valid(out_valid), .out_ready(out_ready),
    .wbOut(wbOut), .mOut(mOut), .resultOut(resultOut), .writeDataOut(writeDataOut),
    .registerRdOut(registerRdOut), .registerRtOut(registerRtOut), .stall_cnt(stall_cnt)
  );

  ex_mem_pipe_stage #(.STALL_CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s),
    .wbIn(wbIn), .mIn(mIn), .resultIn(resultIn), .writeDataIn(writeDataIn),
    .registerRdIn(registerRdIn), .registerRtIn(registerRtIn),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .wbOut(wbOut_s), .mOut(mOut_s), .resultOut(resultOut_s), .writeDataOut(writeDataOut_s),
    .registerRdOut(registerRdOut_s), .registerRtOut(registerRtOut_s), .stall_cnt(stall_cnt_s)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic payload_t mk(input logic [1:0] wb, input logic [1:0] m, input logic [31:0] res);
    payload_t p;
    p.wb         = wb;
    p.m          = m;
    p.result     = res;
    p.write_data = $urandom;
    p.rd         = 5'($urandom);
    p.rt         = 5'($urandom);
    return p;
  endfunction

  // One clock of stimulus; accepted payloads are queued as the expected output order.
  task automatic cycle(input logic iv, input logic ordy, input logic fl, input payload_t p);
    bit model_rdy;
    @(posedge clk);
    #1;
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    {wbIn, mIn, resultIn, writeDataIn, registerRdIn, registerRtIn} = p;
    model_rdy = (exp_q.size() < 2);
    #6;
    if (fl) exp_q.delete();
    else if (iv && model_rdy) exp_q.push_back(p);
    $display("cycle t=%0t in_valid=%0b out_ready=%0b flush=%0b result=%08h held=%0d",
             $time, iv, ordy, fl, p.result, exp_q.size());
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      bit ev;
      ev = (exp_q.size() > 0);
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
      if (ev) begin
        chk("wbOut", 64'(wbOut), 64'(exp_q[0].wb));
        chk("mOut", 64'(mOut), 64'(exp_q[0].m));
        chk("resultOut", 64'(resultOut), 64'(exp_q[0].result));
        chk("writeDataOut", 64'(writeDataOut), 64'(exp_q[0].write_data));
        chk("registerRdOut", 64'(registerRdOut), 64'(exp_q[0].rd));
        chk("registerRtOut", 64'(registerRtOut), 64'(exp_q[0].rt));
      end else begin
        chk("bubble_wb", 64'(wbOut), 64'd0);
        chk("bubble_m", 64'(mOut), 64'd0);
      end
      chk("stall_cnt", 64'(stall_cnt), 64'(stall_exp));
      chk("stall_cnt_sat", 64'(stall_cnt_s), 64'(stall_exp4));
      if (ev && !out_ready) begin
        if (stall_exp != 65535) stall_exp++;
        if (stall_exp4 != 15) stall_exp4++;
      end
      if (ev && out_ready && !flush) void'(exp_q.pop_front());
    end
  end

  initial begin
    payload_t idle;
    idle = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_wbOut", 64'(wbOut), 64'd0);
    chk("reset_resultOut", 64'(resultOut), 64'd0);
    chk("reset_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst    = 1'b1;
    mon_en = 1'b1;

    // First transfer, then an 8-deep stream with MEM always ready.
    cycle(1, 1, 0, mk(2'b10, 2'b01, 32'h1234_5678));
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, mk(2'($urandom), 2'($urandom), 32'(i)));

    // Skid fill with three stall cycles, then drain.
    cycle(1, 1, 0, mk(2'b11, 2'b10, 32'hA));
    cycle(1, 0, 0, mk(2'b01, 2'b11, 32'hB));
    cycle(0, 0, 0, idle);
    cycle(0, 0, 0, idle);
    cycle(0, 1, 0, idle);
    cycle(0, 1, 0, idle);
    cycle(0, 1, 0, idle);

    // Flush while both entries are held and a new input is offered.
    cycle(1, 0, 0, mk(2'b11, 2'b11, 32'hC));
    cycle(1, 0, 0, mk(2'b11, 2'b11, 32'hD));
    cycle(1, 1, 1, mk(2'b11, 2'b11, 32'hE));
    repeat (3) cycle(0, 1, 0, idle);

    // Long stall to saturate the 4-bit counter.
    cycle(1, 0, 0, mk(2'b11, 2'b11, 32'hF));
    repeat (20) cycle(0, 0, 0, idle);

    // Asynchronous reset while both entries are held.
    cycle(1, 0, 0, mk(2'b11, 2'b11, 32'h6));
    cycle(0, 0, 0, idle);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #1;
    mon_en = 1'b0;
    rst    = 1'b0;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_wbOut", 64'(wbOut), 64'd0);
    chk("async_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("async_stall_cnt_sat", 64'(stall_cnt_s), 64'd0);
    chk("async_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    stall_exp  = 0;
    stall_exp4 = 0;
    #3;
    rst    = 1'b1;
    mon_en = 1'b1;

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0),
            mk(2'($urandom), 2'($urandom), $urandom));
    end
    repeat (4) cycle(0, 1, 0, idle);

    @(posedge clk);
    #1;
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
